ahb_slave_interface: RTL and testbench
======================================

# ahb_slave_interface

AHB-facing front end of the AHB-to-APB bridge, sitting directly upstream of the APB controller. It qualifies AHB address phases, decodes the target APB slave, pipelines address/write-data/direction for the controller, returns read data to the master, and generates the two-cycle AHB ERROR response for illegal transfers. The controller consumes `valid`, `tempselx`, `Haddr1`, `Haddr2`, `Hwdata1`, `Hwdata2` and `Hwritereg`.

## Interface
- `S0_BASE`, 32'h8000_0000, base of APB slave 0 region
- `S1_BASE`, 32'h8400_0000, base of APB slave 1 region
- `S2_BASE`, 32'h8800_0000, base of APB slave 2 region
- `REGION_LOG2`, 26, log2 of region size (64 MiB each)
- `Hclk` in 1: single clock, all state on rising edge
- `Hreset` in 1: synchronous, active-high reset
- `Hwrite` in 1: AHB direction (1 = write)
- `Hreadyin` in 1: AHB HREADY from the bus (transfer accepted when 1)
- `Htrans` in 2: 00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ
- `Hsize` in 3: transfer size (0 byte, 1 half, 2 word)
- `Haddr` in 32: address-phase address
- `Hwdata` in 32: data-phase write data
- `Prdata` in 32: read data from the APB side
- `valid` out 1: legal, mapped, active transfer in the current address phase
- `tempselx` out 3: one-hot slave select decoded from `Haddr`
- `Haddr1`, `Haddr2` out 32: address pipeline stages 1 and 2
- `Hwdata1`, `Hwdata2` out 32: write-data pipeline stages 1 and 2
- `Hwritereg` out 1: `Hwrite` registered with stage 1
- `Hrdata` out 32: read data to the master
- `Hresp` out 2: 00 OKAY, 01 ERROR
- `err_hold` out 1: forces bridge HREADYOUT low (first ERROR cycle)
- `err_count` out 8: saturating count of ERROR responses

## Operation
- Active phase: `Hreadyin`=1 and `Htrans` ∈ {10, 11}. IDLE/BUSY never produce `valid` or errors.
- Decode (combinational): `tempselx`=001/010/100 when `Haddr[31:REGION_LOG2]` matches S0/S1/S2 base upper bits; 000 otherwise.
- Illegal: active phase with `tempselx`=000, or `Hsize`>2, or misaligned (`Hsize`=1 and `Haddr[0]`, `Hsize`=2 and `Haddr[1:0]`≠0).
- `valid` = active phase & legal & FSM not in ERR1 & not `Hreset`.
- Pipeline, updated only when `Hreadyin`=1: `Haddr1`←`Haddr`, `Haddr2`←`Haddr1`, `Hwdata1`←`Hwdata`, `Hwdata2`←`Hwdata1`, `Hwritereg`←`Hwrite`. Hold when `Hreadyin`=0.
- `Hrdata` = `Prdata` (combinational passthrough).
- Error FSM, states IDLE, ERR1, ERR2:
  - IDLE: illegal active phase → ERR1; else stay. `Hresp`=00, `err_hold`=0.
  - ERR1: `Hresp`=01, `err_hold`=1; unconditionally → ERR2. Inputs ignored.
  - ERR2: `Hresp`=01, `err_hold`=0. Current address phase evaluated normally: illegal → ERR1, legal → `valid` asserted and → IDLE, otherwise → IDLE.
- `err_count` increments on every IDLE/ERR2 → ERR1 transition; saturates at 255.
- Illegal transfers never assert `valid`, so the controller never starts an APB access for them.

## Timing
- Reset (`Hreset`=1 at a rising edge): FSM→IDLE; `Haddr1`, `Haddr2`, `Hwdata1`, `Hwdata2`=0; `Hwritereg`=0; `err_count`=0. `Hresp`=00, `err_hold`=0 from the next cycle. `valid`=0 throughout reset. Reset mid-error aborts the ERROR sequence immediately.
- `valid`/`tempselx`: zero latency, same cycle as the address phase.
- `Haddr1`/`Hwritereg`: one cycle after accepted address phase; `Haddr2` two cycles.
- `Hwdata1` captures data-phase `Hwdata` at the end of the data phase (one cycle after it is driven).
- Illegal phase at edge N: ERR1 during cycle N+1 (`Hresp`=01, `err_hold`=1), ERR2 during N+2 (`Hresp`=01, `err_hold`=0), IDLE at N+3 unless a new illegal phase is sampled in N+2.
- Back-to-back illegal transfers: ERR2→ERR1 directly; no OKAY cycle between.
- `Hreadyin`=0 stall: pipeline frozen, `valid`=0, FSM unaffected except ERR1→ERR2 progression.

## Test plan
- Reset: hold `Hreset` 2 cycles with random inputs → all pipeline outputs 0, `Hresp`=00, `err_hold`=0, `err_count`=0, `valid`=0.
- Legal write NONSEQ `Haddr`=8400_0010, `Hsize`=2, `Hwdata`=DEAD_BEEF next cycle → `valid`=1, `tempselx`=010 same cycle; `Haddr1`=8400_0010, `Hwritereg`=1 next cycle; `Hwdata1`=DEAD_BEEF following cycle; `Haddr2`=8400_0010 two cycles after.
- Unmapped read NONSEQ `Haddr`=9000_0000 → `valid`=0, `tempselx`=000; next two cycles `Hresp`=01 with `err_hold`=1 then 0; `err_count`=1.
- Misaligned `Hsize`=2 `Haddr`=8000_0002, then legal NONSEQ 8800_0000 during ERR2 → ERROR sequence, `valid`=1 with `tempselx`=100 in ERR2 cycle, FSM IDLE after.
- Stall: `Hreadyin`=0 for 3 cycles with NONSEQ 8000_0004 → `valid`=0, `Haddr1` unchanged; `Htrans`=BUSY/IDLE with `Hreadyin`=1 → `valid`=0, no error.
- 260 consecutive illegal transfers → `err_count` stops at 255; `Hreset` mid-ERR1 → `Hresp`=00 next cycle.

Source files
------------

// File: rtl/ahb_slave_interface_if.sv
// AHB slave-side bundle between the bus/master and the bridge front end.
// Latency: none, wiring only.
// Backpressure: none here; stalls are carried by Hreadyin and err_hold.
// Ports: master drives Hwrite/Hreadyin/Htrans/Hsize/Haddr/Hwdata/Prdata,
//        slave drives decode, pipeline, read data and error response.
interface ahb_slave_interface_if;
    logic        Hwrite;
    logic        Hreadyin;
    logic [1:0]  Htrans;
    logic [2:0]  Hsize;
    logic [31:0] Haddr;
    logic [31:0] Hwdata;
    logic [31:0] Prdata;

    logic        valid;
    logic [2:0]  tempselx;
    logic [31:0] Haddr1;
    logic [31:0] Haddr2;
    logic [31:0] Hwdata1;
    logic [31:0] Hwdata2;
    logic        Hwritereg;
    logic [31:0] Hrdata;
    logic [1:0]  Hresp;
    logic        err_hold;
    logic [7:0]  err_count;

    modport slave (
        input  Hwrite, Hreadyin, Htrans, Hsize, Haddr, Hwdata, Prdata,
        output valid, tempselx, Haddr1, Haddr2, Hwdata1, Hwdata2,
               Hwritereg, Hrdata, Hresp, err_hold, err_count
    );

    modport master (
        output Hwrite, Hreadyin, Htrans, Hsize, Haddr, Hwdata, Prdata,
        input  valid, tempselx, Haddr1, Haddr2, Hwdata1, Hwdata2,
               Hwritereg, Hrdata, Hresp, err_hold, err_count
    );
endinterface

// File: rtl/ahb_slave_interface.sv
// AHB front end of the AHB-to-APB bridge: qualify, decode, pipeline, ERROR response.
// Latency: valid/tempselx/Hrdata combinational; Haddr1/Hwritereg 1 cycle, Haddr2 2 cycles.
// Backpressure: pipeline frozen while Hreadyin=0; err_hold stalls the master in ERR1.
// Ports: Hclk, Hreset (sync, active-high), bus (ahb_slave_interface_if.slave).
module ahb_slave_interface #(
    parameter logic [31:0] S0_BASE     = 32'h8000_0000,
    parameter logic [31:0] S1_BASE     = 32'h8400_0000,
    parameter logic [31:0] S2_BASE     = 32'h8800_0000,
    parameter int          REGION_LOG2 = 26
) (
    input  logic                   Hclk,
    input  logic                   Hreset,
    ahb_slave_interface_if.slave   bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ERR1 = 2'd1,
        ST_ERR2 = 2'd2
    } state_t;

    state_t      state;
    logic [1:0]  hresp_q;
    logic        err_hold_q;
    logic [7:0]  err_count_q;

    logic [31:0] haddr1_q, haddr2_q, hwdata1_q, hwdata2_q;
    logic        hwritereg_q;

    logic        active;
    logic [2:0]  sel;
    logic        misaligned;
    logic        illegal;

    // Only NONSEQ/SEQ with HREADY high form a real address phase.
    assign active = bus.Hreadyin & bus.Htrans[1];

    always_comb begin
        sel = 3'b000;
        if (bus.Haddr[31:REGION_LOG2] == S0_BASE[31:REGION_LOG2])
            sel = 3'b001;
        else if (bus.Haddr[31:REGION_LOG2] == S1_BASE[31:REGION_LOG2])
            sel = 3'b010;
        else if (bus.Haddr[31:REGION_LOG2] == S2_BASE[31:REGION_LOG2])
            sel = 3'b100;
    end

    assign misaligned = ((bus.Hsize == 3'd1) && bus.Haddr[0]) ||
                        ((bus.Hsize == 3'd2) && (bus.Haddr[1:0] != 2'b00));

    assign illegal = active & ((sel == 3'b000) | (bus.Hsize > 3'd2) | misaligned);

    // ERR1 ignores the bus entirely; ERR2 evaluates the new phase normally.
    assign bus.valid    = active & ~illegal & (state != ST_ERR1) & ~Hreset;
    assign bus.tempselx = sel;
    assign bus.Hrdata   = bus.Prdata;

    // Error FSM with registered response outputs.
    always_ff @(posedge Hclk) begin
        if (Hreset) begin
            state       <= ST_IDLE;
            hresp_q     <= 2'b00;
            err_hold_q  <= 1'b0;
            err_count_q <= 8'd0;
        end else begin
            case (state)
                ST_ERR1: begin
                    state      <= ST_ERR2;
                    hresp_q    <= 2'b01;
                    err_hold_q <= 1'b0;
                end
                default: begin
                    if (illegal) begin
                        state      <= ST_ERR1;
                        hresp_q    <= 2'b01;
                        err_hold_q <= 1'b1;
                        if (err_count_q != 8'hFF)
                            err_count_q <= err_count_q + 8'd1;
                    end else begin
                        state      <= ST_IDLE;
                        hresp_q    <= 2'b00;
                        err_hold_q <= 1'b0;
                    end
                end
            endcase
        end
    end

    // Address/data/direction pipeline for the APB controller.
    always_ff @(posedge Hclk) begin
        if (Hreset) begin
            haddr1_q    <= 32'd0;
            haddr2_q    <= 32'd0;
            hwdata1_q   <= 32'd0;
            hwdata2_q   <= 32'd0;
            hwritereg_q <= 1'b0;
        end else if (bus.Hreadyin) begin
            haddr1_q    <= bus.Haddr;
            haddr2_q    <= haddr1_q;
            hwdata1_q   <= bus.Hwdata;
            hwdata2_q   <= hwdata1_q;
            hwritereg_q <= bus.Hwrite;
        end
    end

    assign bus.Haddr1    = haddr1_q;
    assign bus.Haddr2    = haddr2_q;
    assign bus.Hwdata1   = hwdata1_q;
    assign bus.Hwdata2   = hwdata2_q;
    assign bus.Hwritereg = hwritereg_q;
    assign bus.Hresp     = hresp_q;
    assign bus.err_hold  = err_hold_q;
    assign bus.err_count = err_count_q;

endmodule

// File: tb/tb_ahb_slave_interface.sv
// Randomized + directed bench for ahb_slave_interface against a behavioural model.
// Latency: outputs compared every cycle at the falling edge.
// Backpressure: stimulus exercises Hreadyin stalls and back-to-back errors.
module tb_ahb_slave_interface;

    logic Hclk;
    logic Hreset;

    ahb_slave_interface_if bus ();

    ahb_slave_interface dut (
        .Hclk   (Hclk),
        .Hreset (Hreset),
        .bus    (bus.slave)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model: time since the last illegal phase, plus plain copies
    // of what each pipeline stage must hold.
    bit          chk_en = 0;
    int          m_age  = 0;   // 0 none, 1 first ERROR cycle, 2 second ERROR cycle
    int          m_cnt  = 0;
    logic [31:0] m_a1, m_a2, m_w1, m_w2;
    logic        m_wr;

    initial begin
        Hclk = 1'b0;
        forever #5 Hclk = ~Hclk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [2:0] model_sel(input logic [31:0] a);
        if (a >= 32'h8000_0000 && a < 32'h8400_0000) return 3'b001;
        if (a >= 32'h8400_0000 && a < 32'h8800_0000) return 3'b010;
        if (a >= 32'h8800_0000 && a < 32'h8C00_0000) return 3'b100;
        return 3'b000;
    endfunction

    function automatic bit model_legal(input logic [31:0] a, input logic [2:0] sz);
        if (sz > 3'd2) return 1'b0;
        if ((a % (32'd1 << sz)) != 0) return 1'b0;
        return model_sel(a) != 3'b000;
    endfunction

    function automatic bit model_active();
        return bus.Hreadyin && (bus.Htrans >= 2'd2);
    endfunction

    // Model update on every rising edge, from the inputs sampled there.
    always @(posedge Hclk) begin
        if (Hreset) begin
            m_age = 0; m_cnt = 0;
            m_a1 = 0; m_a2 = 0; m_w1 = 0; m_w2 = 0; m_wr = 0;
            chk_en = 1;
        end else begin
            if (bus.Hreadyin) begin
                m_a2 = m_a1; m_a1 = bus.Haddr;
                m_w2 = m_w1; m_w1 = bus.Hwdata;
                m_wr = bus.Hwrite;
            end
            if (m_age == 1) begin
                m_age = 2;
            end else if (model_active() && !model_legal(bus.Haddr, bus.Hsize)) begin
                m_age = 1;
                if (m_cnt < 255) m_cnt = m_cnt + 1;
            end else begin
                m_age = 0;
            end
        end
    end

    // Single compare process: every output, every cycle after the first reset edge.
    always @(negedge Hclk) begin
        if (chk_en) begin
            automatic bit exp_valid = model_active() && model_legal(bus.Haddr, bus.Hsize)
                                      && (m_age != 1) && !Hreset;
            chk("valid",     {31'd0, bus.valid},     {31'd0, exp_valid});
            chk("tempselx",  {29'd0, bus.tempselx},  {29'd0, model_sel(bus.Haddr)});
            chk("Haddr1",    bus.Haddr1,  m_a1);
            chk("Haddr2",    bus.Haddr2,  m_a2);
            chk("Hwdata1",   bus.Hwdata1, m_w1);
            chk("Hwdata2",   bus.Hwdata2, m_w2);
            chk("Hwritereg", {31'd0, bus.Hwritereg}, {31'd0, m_wr});
            chk("Hrdata",    bus.Hrdata,  bus.Prdata);
            chk("Hresp",     {30'd0, bus.Hresp},     (m_age != 0) ? 32'd1 : 32'd0);
            chk("err_hold",  {31'd0, bus.err_hold},  (m_age == 1) ? 32'd1 : 32'd0);
            chk("err_count", {24'd0, bus.err_count}, m_cnt[31:0]);
        end
    end

    task automatic tick();
        @(posedge Hclk);
        #1;
    endtask

    function automatic logic [31:0] rand_addr();
        int k;
        k = $urandom_range(0, 4);
        case (k)
            0: return 32'h8000_0000 + $urandom_range(0, 255);
            1: return 32'h8400_0000 + $urandom_range(0, 255);
            2: return 32'h8800_0000 + $urandom_range(0, 255);
            3: return 32'h83FF_FF00 + $urandom_range(0, 511);
            default: return $urandom;
        endcase
    endfunction

    task automatic drive_random(input bit allow_reset);
        bus.Hwrite   = 1'($urandom_range(0, 1));
        bus.Hreadyin = ($urandom_range(0, 9) < 8);
        bus.Htrans   = 2'($urandom_range(0, 3));
        bus.Hsize    = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(3, 7))
                                                   : 3'($urandom_range(0, 2));
        bus.Haddr    = rand_addr();
        bus.Hwdata   = $urandom;
        bus.Prdata   = $urandom;
        if (allow_reset) Hreset = ($urandom_range(0, 63) == 0);
    endtask

    task automatic set_idle();
        bus.Htrans   = 2'b00;
        bus.Hreadyin = 1'b1;
        bus.Hwrite   = 1'b0;
    endtask

    task automatic phase(input logic [1:0] tr, input logic wr,
                         input logic [2:0] sz, input logic [31:0] a);
        bus.Htrans   = tr;
        bus.Hwrite   = wr;
        bus.Hsize    = sz;
        bus.Haddr    = a;
        bus.Hreadyin = 1'b1;
    endtask

    initial begin
        bit found;

        // Reset held two cycles with random inputs.
        Hreset = 1'b1;
        drive_random(0);
        tick();
        drive_random(0);
        @(negedge Hclk);
        chk("rst_valid",    {31'd0, bus.valid},     32'd0);
        chk("rst_Haddr1",   bus.Haddr1,             32'd0);
        chk("rst_Hwdata2",  bus.Hwdata2,            32'd0);
        chk("rst_Hresp",    {30'd0, bus.Hresp},     32'd0);
        chk("rst_err_hold", {31'd0, bus.err_hold},  32'd0);
        chk("rst_err_cnt",  {24'd0, bus.err_count}, 32'd0);
        tick();
        Hreset = 1'b0;

        // Legal word write to slave 1.
        phase(2'b10, 1'b1, 3'd2, 32'h8400_0010);
        bus.Hwdata = 32'h0;
        @(negedge Hclk);
        chk("wr_valid",    {31'd0, bus.valid},    32'd1);
        chk("wr_tempselx", {29'd0, bus.tempselx}, 32'd2);
        tick();
        set_idle();
        bus.Hwdata = 32'hDEAD_BEEF;
        @(negedge Hclk);
        chk("wr_Haddr1",    bus.Haddr1,             32'h8400_0010);
        chk("wr_Hwritereg", {31'd0, bus.Hwritereg}, 32'd1);
        tick();
        @(negedge Hclk);
        chk("wr_Hwdata1", bus.Hwdata1, 32'hDEAD_BEEF);
        chk("wr_Haddr2",  bus.Haddr2,  32'h8400_0010);
        tick();

        // Unmapped read.
        phase(2'b10, 1'b0, 3'd2, 32'h9000_0000);
        @(negedge Hclk);
        chk("um_valid",    {31'd0, bus.valid},    32'd0);
        chk("um_tempselx", {29'd0, bus.tempselx}, 32'd0);
        tick();
        set_idle();
        @(negedge Hclk);
        chk("um_e1_Hresp", {30'd0, bus.Hresp},     32'd1);
        chk("um_e1_hold",  {31'd0, bus.err_hold},  32'd1);
        chk("um_err_cnt",  {24'd0, bus.err_count}, 32'd1);
        tick();
        @(negedge Hclk);
        chk("um_e2_Hresp", {30'd0, bus.Hresp},    32'd1);
        chk("um_e2_hold",  {31'd0, bus.err_hold}, 32'd0);
        tick();
        @(negedge Hclk);
        chk("um_okay", {30'd0, bus.Hresp}, 32'd0);

        // Misaligned word, then a legal phase during ERR2.
        phase(2'b10, 1'b0, 3'd2, 32'h8000_0002);
        tick();
        set_idle();
        tick();
        phase(2'b10, 1'b0, 3'd2, 32'h8800_0000);
        @(negedge Hclk);
        chk("ma_e2_Hresp",  {30'd0, bus.Hresp},    32'd1);
        chk("ma_e2_valid",  {31'd0, bus.valid},    32'd1);
        chk("ma_e2_sel",    {29'd0, bus.tempselx}, 32'd4);
        tick();
        set_idle();
        @(negedge Hclk);
        chk("ma_okay",    {30'd0, bus.Hresp},     32'd0);
        chk("ma_err_cnt", {24'd0, bus.err_count}, 32'd2);
        tick();

        // Stall with a pending NONSEQ, then BUSY to an unmapped address.
        phase(2'b10, 1'b0, 3'd2, 32'h8000_0004);
        bus.Hreadyin = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge Hclk);
            chk("st_valid",  {31'd0, bus.valid}, 32'd0);
            chk("st_Haddr1", bus.Haddr1,         32'h8800_0000);
            tick();
        end
        phase(2'b01, 1'b0, 3'd2, 32'h9000_0000);
        tick();
        set_idle();
        @(negedge Hclk);
        chk("busy_Hresp",   {30'd0, bus.Hresp},     32'd0);
        chk("busy_err_cnt", {24'd0, bus.err_count}, 32'd2);
        tick();

        // Randomized traffic, checked by the compare process.
        for (int i = 0; i < 2000; i++) begin
            drive_random(1);
            tick();
        end
        Hreset = 1'b1;
        set_idle();
        tick();
        Hreset = 1'b0;

        // Continuous illegal traffic: counter must saturate.
        phase(2'b10, 1'b0, 3'd2, 32'h9000_0000);
        for (int i = 0; i < 600; i++) tick();
        @(negedge Hclk);
        chk("sat_err_cnt", {24'd0, bus.err_count}, 32'd255);
        chk("sat_model",   m_cnt[31:0],             32'd255);

        // Reset in the middle of ERR1 aborts the ERROR response.
        found = 0;
        for (int i = 0; i < 4; i++) begin
            if (m_age == 1) begin
                found = 1;
                break;
            end
            tick();
        end
        chk("find_err1", {31'd0, found}, 32'd1);
        Hreset = 1'b1;
        @(negedge Hclk);
        chk("mid_e1_hold", {31'd0, bus.err_hold}, 32'd1);
        tick();
        Hreset = 1'b0;
        set_idle();
        @(negedge Hclk);
        chk("abort_Hresp",   {30'd0, bus.Hresp},     32'd0);
        chk("abort_hold",    {31'd0, bus.err_hold},  32'd0);
        chk("abort_err_cnt", {24'd0, bus.err_count}, 32'd0);
        tick();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
